// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the 2x2 matrix-multiply sequencer.
// Holds the FSM state encoding and the default sizing constants.
package matmul_pkg;

   // Sequencer states: idle, multiplier strobe, regfile write, accumulate, complete
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MULT = 3'd1,
      ST_LOAD = 3'd2,
      ST_ADD  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Number of A/B element products per 2x2 by 2x2 operation
   localparam int NUM_ENTRIES_DEFAULT = 8;

   // Maximum number of ADD-state wait cycles when the accumulate timeout is built in
   localparam int ADD_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/matmul_entry_counter.sv
// matmul_entry_counter: product index for the sequencer.
// Provides the element select / regfile address, with a synchronous clear,
// an increment and a flag marking the final product of an operation.
module matmul_entry_counter #(
   parameter int NUM_ENTRIES = 8
) (
   input  logic                           clock,
   input  logic                           clear,
   input  logic                           increment,
   output logic [$clog2(NUM_ENTRIES)-1:0] entry_index,
   output logic                           last
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);

   // Clear has priority so a reset or return to idle always lands on entry 0
   always_ff @(posedge clock) begin
      if (clear) begin
         entry_index <= '0;
      end else if (increment) begin
         entry_index <= entry_index + IDX_W'(1);
      end
   end

   assign last = (entry_index == IDX_W'(NUM_ENTRIES - 1));

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: control FSM for a 2x2 by 2x2 matrix multiply.
// Walks the element products through MULT/LOAD pairs, waits in ADD for the
// accumulator, then pulses done and counts the completed result.
// Optional feature: define MATMUL_SEQ_ADD_TIMEOUT_EN to abandon an ADD wait
// after ADD_TIMEOUT cycles with a timeout_err pulse; otherwise ADD waits forever.
module matmul_sequencer
   import matmul_pkg::*;
#(
   parameter int NUM_ENTRIES = NUM_ENTRIES_DEFAULT,
   parameter int COUNT_W     = 8,
   parameter int ADD_TIMEOUT = ADD_TIMEOUT_DEFAULT
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           add_done,
   output logic [$clog2(NUM_ENTRIES)-1:0] entry_index,
   output logic                           multiply,
   output logic                           load,
   output logic                           add,
   output logic                           busy,
   output logic                           done,
   output logic                           timeout_err,
   output logic [COUNT_W-1:0]             matrix_count
);

   state_t state;
   logic   last_entry;
   logic   entry_clear;
   logic   entry_inc;

   // A zero timeout would make ADD give up before the accumulator could answer
   if (ADD_TIMEOUT < 1) begin : g_bad_timeout
      $error("matmul_sequencer: ADD_TIMEOUT must be at least 1");
   end

   // Index returns to 0 whenever idle (and across reset); it advances only
   // when a LOAD finishes a product that is not the last one
   assign entry_clear = reset || (state == ST_IDLE) || (state == ST_DONE);
   assign entry_inc   = (state == ST_LOAD) && !last_entry;

   matmul_entry_counter #(
      .NUM_ENTRIES (NUM_ENTRIES)
   ) u_entry_counter (
      .clock       (clock),
      .clear       (entry_clear),
      .increment   (entry_inc),
      .entry_index (entry_index),
      .last        (last_entry)
   );

`ifdef MATMUL_SEQ_ADD_TIMEOUT_EN
   localparam int WAIT_W = $clog2(ADD_TIMEOUT + 1);
   logic [WAIT_W-1:0] wait_count;

   // Sequencer FSM with registered strobes and an ADD wait-cycle limit
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         multiply     <= 1'b0;
         load         <= 1'b0;
         add          <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout_err  <= 1'b0;
         matrix_count <= '0;
         wait_count   <= '0;
      end else begin
         multiply    <= 1'b0;
         load        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_MULT;
                  multiply <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ST_MULT: begin
               state <= ST_LOAD;
               load  <= 1'b1;
            end
            ST_LOAD: begin
               if (last_entry) begin
                  state      <= ST_ADD;
                  add        <= 1'b1;
                  wait_count <= '0;
               end else begin
                  state    <= ST_MULT;
                  multiply <= 1'b1;
               end
            end
            ST_ADD: begin
               if (add_done) begin
                  state        <= ST_DONE;
                  add          <= 1'b0;
                  done         <= 1'b1;
                  matrix_count <= matrix_count + COUNT_W'(1);
               end else if (wait_count == WAIT_W'(ADD_TIMEOUT - 1)) begin
                  state       <= ST_DONE;
                  add         <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  wait_count <= wait_count + WAIT_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               add   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end
`else
   assign timeout_err = 1'b0;

   // Sequencer FSM with registered strobes; ADD waits for add_done indefinitely
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         multiply     <= 1'b0;
         load         <= 1'b0;
         add          <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         matrix_count <= '0;
      end else begin
         multiply <= 1'b0;
         load     <= 1'b0;
         done     <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_MULT;
                  multiply <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ST_MULT: begin
               state <= ST_LOAD;
               load  <= 1'b1;
            end
            ST_LOAD: begin
               if (last_entry) begin
                  state <= ST_ADD;
                  add   <= 1'b1;
               end else begin
                  state    <= ST_MULT;
                  multiply <= 1'b1;
               end
            end
            ST_ADD: begin
               if (add_done) begin
                  state        <= ST_DONE;
                  add          <= 1'b0;
                  done         <= 1'b1;
                  matrix_count <= matrix_count + COUNT_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               add   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end
`endif

endmodule
